// File: rtl/ram_sequencer.sv
// DRAM-to-SRAM bridge: synchronizes asynchronous host DRAM strobes and replays them as SRAM cycles.
// Optional REFRESH_CNT_EN macro adds a 16-bit count of CAS-before-RAS refresh entries.
module ram_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [8:0]  Ain,
  input  logic        RAS_n,
  input  logic        CASU_n,
  input  logic        CASL_n,
  input  logic        WE_n,
  input  logic        OEin_n,
  output logic [17:0] Aout,
  output logic        CE_n,
  output logic        OEout_n,
  output logic        WEout_n,
  output logic        UB_n,
  output logic        LB_n,
`ifdef REFRESH_CNT_EN
  output logic [15:0] refresh_cnt,
`endif
  output logic        busy
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ROW     = 3'd1,
    ST_ACCESS  = 3'd2,
    ST_PAGE    = 3'd3,
    ST_REFRESH = 3'd4
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [8:0]  r_ain_m;
  logic [8:0]  r_ain_s;
  logic [4:0]  r_strb_m;
  logic [4:0]  r_strb_s;
  logic        r_ras_d;
  logic [1:0]  r_vld_cnt;
  logic [8:0]  r_row;
  logic        r_write;
  logic [17:0] r_aout;
  logic        r_ce_n;
  logic        r_oe_n;
  logic        r_we_n;
  logic        r_ub_n;
  logic        r_lb_n;
  logic        r_busy;
  logic        w_ras_s;
  logic        w_casu_s;
  logic        w_casl_s;
  logic        w_we_s;
  logic        w_oe_s;
  logic        w_ras_fall;
  logic        w_row_ld;
  logic        w_col_ld;
  logic        w_wr;
  logic        w_ce_n;
  logic        w_oe_n;
  logic        w_we_n;
  logic        w_ub_n;
  logic        w_lb_n;

  assign w_ras_s  = r_strb_s[4];
  assign w_casu_s = r_strb_s[3];
  assign w_casl_s = r_strb_s[2];
  assign w_we_s   = r_strb_s[1];
  assign w_oe_s   = r_strb_s[0];

  // A falling edge is only trusted once the synchronizer has flushed its reset
  // contents, so a RAS already low at reset release cannot start a cycle.
  assign w_ras_fall = (r_vld_cnt == 2'd3) && r_ras_d && !w_ras_s;

  // Two-flop synchronizer for every host input, plus edge-detect history
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ain_m   <= 9'd0;
      r_ain_s   <= 9'd0;
      r_strb_m  <= 5'b11111;
      r_strb_s  <= 5'b11111;
      r_ras_d   <= 1'b1;
      r_vld_cnt <= 2'd0;
    end else begin
      r_ain_m   <= Ain;
      r_ain_s   <= r_ain_m;
      r_strb_m  <= {RAS_n, CASU_n, CASL_n, WE_n, OEin_n};
      r_strb_s  <= r_strb_m;
      r_ras_d   <= w_ras_s;
      if (r_vld_cnt != 2'd3) begin
        r_vld_cnt <= r_vld_cnt + 2'd1;
      end
    end
  end

  // Next-state decode; RAS release always takes priority over CAS activity
  always_comb begin
    w_state_nxt = r_state;
    w_row_ld    = 1'b0;
    w_col_ld    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_ras_fall) begin
          if (w_casu_s && w_casl_s) begin
            w_state_nxt = ST_ROW;
            w_row_ld    = 1'b1;
          end else begin
            w_state_nxt = ST_REFRESH;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ROW, ST_PAGE: begin
        if (w_ras_s) begin
          w_state_nxt = ST_IDLE;
        end else if (!w_casu_s || !w_casl_s) begin
          w_state_nxt = ST_ACCESS;
          w_col_ld    = 1'b1;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_ACCESS: begin
        if (w_ras_s) begin
          w_state_nxt = ST_IDLE;
        end else if (w_casu_s && w_casl_s) begin
          w_state_nxt = ST_PAGE;
        end else begin
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_REFRESH: begin
        if (w_ras_s) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_REFRESH;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // SRAM strobe values for the state being entered; write strobe waits one cycle for address setup
  always_comb begin
    w_ce_n = 1'b1;
    w_oe_n = 1'b1;
    w_we_n = 1'b1;
    w_ub_n = 1'b1;
    w_lb_n = 1'b1;
    w_wr   = w_col_ld ? !w_we_s : r_write;
    if (w_state_nxt == ST_ACCESS) begin
      w_ce_n = 1'b0;
      w_ub_n = w_casu_s;
      w_lb_n = w_casl_s;
      if (w_wr) begin
        w_oe_n = 1'b1;
        w_we_n = (r_state == ST_ACCESS) ? 1'b0 : 1'b1;
      end else begin
        w_oe_n = w_oe_s;
        w_we_n = 1'b1;
      end
    end else begin
      w_ce_n = 1'b1;
    end
  end

  // State, address latches and registered SRAM outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_row   <= 9'd0;
      r_write <= 1'b0;
      r_aout  <= 18'd0;
      r_ce_n  <= 1'b1;
      r_oe_n  <= 1'b1;
      r_we_n  <= 1'b1;
      r_ub_n  <= 1'b1;
      r_lb_n  <= 1'b1;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_row_ld) begin
        r_row <= r_ain_s;
      end
      if (w_col_ld) begin
        r_write <= !w_we_s;
        r_aout  <= {r_ain_s, r_row};
      end
      r_ce_n  <= w_ce_n;
      r_oe_n  <= w_oe_n;
      r_we_n  <= w_we_n;
      r_ub_n  <= w_ub_n;
      r_lb_n  <= w_lb_n;
      r_busy  <= (w_state_nxt != ST_IDLE);
    end
  end

`ifdef REFRESH_CNT_EN
  logic [15:0] r_refresh_cnt;

  // Count CAS-before-RAS refresh entries, wrapping naturally at 16 bits
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_refresh_cnt <= 16'd0;
    end else if ((r_state == ST_IDLE) && (w_state_nxt == ST_REFRESH)) begin
      r_refresh_cnt <= r_refresh_cnt + 16'd1;
    end
  end

  assign refresh_cnt = r_refresh_cnt;
`endif

  assign Aout    = r_aout;
  assign CE_n    = r_ce_n;
  assign OEout_n = r_oe_n;
  assign WEout_n = r_we_n;
  assign UB_n    = r_ub_n;
  assign LB_n    = r_lb_n;
  assign busy    = r_busy;

endmodule
